sat_ctr_predictor_table: RTL and testbench

- Parametrised successor to the single 2-bit saturating-counter branch predictor.
- Holds a table of 2^IDX_W saturating counters of CTR_W bits each, plus a global history register (GHR).
- Counters are indexed either bimodally (PC only) or gshare-style (PC XOR GHR), selected by a parameter.
- Sits between fetch (request/prediction) and branch resolution (result/update). Adds a saturating mispredict statistics counter.

---
 rtl/sat_ctr_predictor_table_if.sv | 43 ++++
 rtl/sat_ctr_predictor_table.sv | 127 ++++++++++++
 tb/tb_sat_ctr_predictor_table.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sat_ctr_predictor_table_if.sv
// -----------------------------------------------------------------------------
// sat_ctr_predictor_table_if
//   Groups the fetch-side lookup signals and the resolve-side update signals
//   of the saturating-counter predictor table.
//
//   Lookup  : request, req_pc -> prediction, pred_valid, pred_hist
//   Update  : result, upd_pc, upd_hist, taken, upd_pred
//   Stats   : mispredicts
//
//   master : the pipeline (fetch + branch resolution) driving the predictor
//   slave  : the predictor table itself
// -----------------------------------------------------------------------------
interface sat_ctr_predictor_table_if #(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int STAT_W = 16
);
  logic              request;
  logic [IDX_W-1:0]  req_pc;
  logic              prediction;
  logic              pred_valid;
  logic [HIST_W-1:0] pred_hist;

  logic              result;
  logic [IDX_W-1:0]  upd_pc;
  logic [HIST_W-1:0] upd_hist;
  logic              taken;
  logic              upd_pred;

  logic [STAT_W-1:0] mispredicts;

  modport master (
    output request, req_pc,
    output result, upd_pc, upd_hist, taken, upd_pred,
    input  prediction, pred_valid, pred_hist, mispredicts
  );

  modport slave (
    input  request, req_pc,
    input  result, upd_pc, upd_hist, taken, upd_pred,
    output prediction, pred_valid, pred_hist, mispredicts
  );
endinterface

// File: rtl/sat_ctr_predictor_table.sv
// -----------------------------------------------------------------------------
// sat_ctr_predictor_table
//   Table of 2^IDX_W saturating counters (CTR_W bits each) with a global
//   history register. Indexing is bimodal (pc) or gshare (pc ^ history),
//   chosen by GSHARE. Lookups have one cycle of latency; updates are applied
//   on the edge where result is high. A lookup and an update on the same edge
//   both see the table and history as they were before that edge; there is no
//   forwarding, even on a same-index collision.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - slave side of sat_ctr_predictor_table_if:
//                request/req_pc          lookup strobe and pc index bits
//                prediction/pred_valid   registered direction, one-cycle valid
//                pred_hist               history used for the lookup
//                result/upd_pc/upd_hist  update strobe, pc and returned history
//                taken/upd_pred          resolved and predicted directions
//                mispredicts             saturating mispredict count
// -----------------------------------------------------------------------------
module sat_ctr_predictor_table #(
  parameter int CTR_W  = 2,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int GSHARE = 1,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sat_ctr_predictor_table_if.slave bus
);

  localparam int DEPTH = 1 << IDX_W;

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_W-1:0]  CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]  CTR_MIN  = '0;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [CTR_W-1:0]  ctr_q [DEPTH];
  logic [HIST_W-1:0] ghr_q;
  logic [STAT_W-1:0] mis_q;

  logic [IDX_W-1:0]  req_idx_p0;
  logic [IDX_W-1:0]  upd_idx_p0;
  logic [CTR_W-1:0]  upd_ctr_p0;
  logic [HIST_W-1:0] ghr_next_p0;
  logic              mispred_p0;

  logic              pred_p1;
  logic              vld_p1;
  logic [HIST_W-1:0] hist_p1;

  // History is narrower than or equal to the index, so it is zero-extended
  // before folding into the pc bits.
  function automatic logic [IDX_W-1:0] fold_idx(input logic [IDX_W-1:0]  pc,
                                                input logic [HIST_W-1:0] hist);
    if (GSHARE != 0) return pc ^ IDX_W'(hist);
    else             return pc;
  endfunction

  // Saturating step in the requested direction; never wraps at either end.
  function automatic logic [CTR_W-1:0] ctr_sat_step(input logic [CTR_W-1:0] c,
                                                    input logic             up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    else    return (c == CTR_MIN) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] s);
    return (s == STAT_MAX) ? s : s + STAT_W'(1);
  endfunction

  // ---- p0: index formation, counter read and next-state computation ----
  assign req_idx_p0  = fold_idx(bus.req_pc, ghr_q);
  assign upd_idx_p0  = fold_idx(bus.upd_pc, bus.upd_hist);
  assign upd_ctr_p0  = ctr_sat_step(ctr_q[upd_idx_p0], bus.taken);
  // Dropping the top bit of {ghr, taken} shifts taken in; also covers HIST_W=1.
  assign ghr_next_p0 = HIST_W'({ghr_q, bus.taken});
  assign mispred_p0  = bus.upd_pred != bus.taken;

  // ---- p0 -> p1: table, history and statistics state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (bus.result) begin
      ctr_q[upd_idx_p0] <= upd_ctr_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else if (bus.result) begin
      ghr_q <= ghr_next_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= '0;
    end else if (bus.result && mispred_p0) begin
      mis_q <= stat_sat_inc(mis_q);
    end
  end

  // ---- p0 -> p1: registered lookup result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      pred_p1 <= 1'b0;
      hist_p1 <= '0;
    end else begin
      vld_p1 <= bus.request;
      if (bus.request) begin
        pred_p1 <= ctr_q[req_idx_p0][CTR_W-1];
        hist_p1 <= ghr_q;
      end
    end
  end

  assign bus.prediction  = pred_p1;
  assign bus.pred_valid  = vld_p1;
  assign bus.pred_hist   = hist_p1;
  assign bus.mispredicts = mis_q;

endmodule

// File: tb/tb_sat_ctr_predictor_table.sv
// -----------------------------------------------------------------------------
// tb_sat_ctr_predictor_table
//   Directed scenarios plus randomized lookups/updates, compared every cycle
//   against an integer-array model of the counter table, history and
//   mispredict statistic.
// -----------------------------------------------------------------------------
module tb_sat_ctr_predictor_table;
  localparam int CTR_W     = 2;
  localparam int IDX_W     = 6;
  localparam int HIST_W    = 6;
  localparam int GSHARE    = 1;
  localparam int STAT_W    = 4;
  localparam int DEPTH     = 1 << IDX_W;
  localparam int CTR_MAX   = (1 << CTR_W) - 1;
  localparam int CTR_INIT  = (1 << (CTR_W - 1)) - 1;
  localparam int CTR_HALF  = 1 << (CTR_W - 1);
  localparam int STAT_MAX  = (1 << STAT_W) - 1;
  localparam int HIST_MASK = (1 << HIST_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sat_ctr_predictor_table_if #(.IDX_W(IDX_W), .HIST_W(HIST_W), .STAT_W(STAT_W)) bus();

  sat_ctr_predictor_table #(
    .CTR_W (CTR_W),
    .IDX_W (IDX_W),
    .HIST_W(HIST_W),
    .GSHARE(GSHARE),
    .STAT_W(STAT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_ctr [DEPTH];
  int m_ghr;
  int m_mis;
  int m_hist;
  int m_pred;
  int m_vld;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_ctr[i] = CTR_INIT;
    m_ghr  = 0;
    m_mis  = 0;
    m_hist = 0;
    m_pred = 0;
    m_vld  = 0;
  endtask

  // Applies one clock edge's worth of behaviour: lookup sees the old state.
  task automatic model_edge();
    int ridx;
    int uidx;
    int new_ghr;
    new_ghr = m_ghr;
    if (bus.request) begin
      ridx   = GSHARE ? (int'(bus.req_pc) ^ m_ghr) : int'(bus.req_pc);
      m_pred = (m_ctr[ridx] >= CTR_HALF) ? 1 : 0;
      m_hist = m_ghr;
      m_vld  = 1;
    end else begin
      m_vld = 0;
    end
    if (bus.result) begin
      uidx = GSHARE ? (int'(bus.upd_pc) ^ int'(bus.upd_hist)) : int'(bus.upd_pc);
      if (bus.taken) m_ctr[uidx] = (m_ctr[uidx] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[uidx] + 1;
      else           m_ctr[uidx] = (m_ctr[uidx] - 1 < 0) ? 0 : m_ctr[uidx] - 1;
      new_ghr = ((m_ghr << 1) | int'(bus.taken)) & HIST_MASK;
      if (bus.upd_pred != bus.taken && m_mis < STAT_MAX) m_mis++;
    end
    m_ghr = new_ghr;
  endtask

  task automatic check_outputs();
    check_val("pred_valid",  32'(bus.pred_valid),  32'(m_vld));
    check_val("prediction",  32'(bus.prediction),  32'(m_pred));
    check_val("pred_hist",   32'(bus.pred_hist),   32'(m_hist));
    check_val("mispredicts", 32'(bus.mispredicts), 32'(m_mis));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bus.request  = 1'b0;
    bus.req_pc   = '0;
    bus.result   = 1'b0;
    bus.upd_pc   = '0;
    bus.upd_hist = '0;
    bus.taken    = 1'b0;
    bus.upd_pred = 1'b0;
  endtask

  // Looks up table entry tgt regardless of current history.
  task automatic lookup_idx(input int tgt);
    bus.request = 1'b1;
    bus.req_pc  = IDX_W'(tgt ^ (GSHARE ? m_ghr : 0));
    tick();
    bus.request = 1'b0;
  endtask

  task automatic update(input int pc, input int hist, input bit tk, input bit pr);
    bus.result   = 1'b1;
    bus.upd_pc   = IDX_W'(pc);
    bus.upd_hist = HIST_W'(hist);
    bus.taken    = tk;
    bus.upd_pred = pr;
    tick();
    bus.result   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #12;
    check_val("rst_pred_valid",  32'(bus.pred_valid),  32'd0);
    check_val("rst_prediction",  32'(bus.prediction),  32'd0);
    check_val("rst_pred_hist",   32'(bus.pred_hist),   32'd0);
    check_val("rst_mispredicts", 32'(bus.mispredicts), 32'd0);
    rst_n = 1'b1;

    // First lookup after reset: weakly not-taken, history zero, one-cycle valid.
    bus.request = 1'b1;
    bus.req_pc  = IDX_W'(5);
    tick();
    bus.request = 1'b0;
    check_val("first_valid", 32'(bus.pred_valid), 32'd1);
    check_val("first_pred",  32'(bus.prediction), 32'd0);
    check_val("first_hist",  32'(bus.pred_hist),  32'd0);
    tick();
    check_val("valid_drop",  32'(bus.pred_valid), 32'd0);

    // Saturation at both ends of entry 5.
    repeat (2) update(5, 0, 1'b1, 1'b1);
    lookup_idx(5);
    check_val("sat_up_pred", 32'(bus.prediction), 32'd1);
    repeat (4) update(5, 0, 1'b1, 1'b1);
    lookup_idx(5);
    check_val("sat_hi_pred", 32'(bus.prediction), 32'd1);
    repeat (2) update(5, 0, 1'b0, 1'b0);
    lookup_idx(5);
    check_val("dec_pred", 32'(bus.prediction), 32'd0);
    repeat (3) update(5, 0, 1'b0, 1'b0);
    update(5, 0, 1'b1, 1'b1);
    lookup_idx(5);
    check_val("sat_lo_pred", 32'(bus.prediction), 32'd0);
    update(5, 0, 1'b1, 1'b1);
    lookup_idx(5);
    check_val("sat_lo_climb", 32'(bus.prediction), 32'd1);

    // Gshare history: three taken at entry 0 from a clean reset.
    do_reset();
    repeat (3) update(0, 0, 1'b1, 1'b1);
    bus.request = 1'b1;
    bus.req_pc  = IDX_W'(7);
    tick();
    bus.request = 1'b0;
    check_val("gs_pred", 32'(bus.prediction), 32'd1);
    check_val("gs_hist", 32'(bus.pred_hist),  32'd7);

    // Same-edge lookup and update of entry 3 (history now 000111).
    bus.request  = 1'b1;
    bus.req_pc   = IDX_W'(3 ^ 7);
    bus.result   = 1'b1;
    bus.upd_pc   = IDX_W'(3);
    bus.upd_hist = '0;
    bus.taken    = 1'b1;
    bus.upd_pred = 1'b1;
    tick();
    idle_inputs();
    check_val("rbw_pred_old", 32'(bus.prediction), 32'd0);
    bus.request = 1'b1;
    bus.req_pc  = IDX_W'(3 ^ 15);
    tick();
    bus.request = 1'b0;
    check_val("rbw_pred_new", 32'(bus.prediction), 32'd1);
    check_val("rbw_hist",     32'(bus.pred_hist),  32'd15);

    // Mispredict statistic saturation.
    for (int i = 0; i < 20; i++) update(i % DEPTH, 0, i[0], ~i[0]);
    check_val("mis_sat", 32'(bus.mispredicts), 32'(STAT_MAX));
    repeat (3) update(9, 0, 1'b1, 1'b1);
    check_val("mis_hold", 32'(bus.mispredicts), 32'(STAT_MAX));

    // Asynchronous reset between a lookup and the next edge.
    bus.request = 1'b1;
    bus.req_pc  = IDX_W'(1);
    tick();
    bus.request = 1'b0;
    check_val("pre_arst_valid", 32'(bus.pred_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(bus.pred_valid),  32'd0);
    check_val("arst_mis",   32'(bus.mispredicts), 32'd0);
    check_val("arst_hist",  32'(bus.pred_hist),   32'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    tick();
    check_val("post_arst_valid", 32'(bus.pred_valid), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx(i);
      check_val("arst_readback", 32'(bus.prediction), 32'd0);
    end
    // One taken step must flip the entry, so it was at 01 rather than 00.
    update(17, 0, 1'b1, 1'b0);
    lookup_idx(17);
    check_val("arst_init_01", 32'(bus.prediction), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      bus.request  = 1'($urandom_range(0, 1));
      bus.req_pc   = IDX_W'($urandom);
      bus.result   = 1'($urandom_range(0, 1));
      bus.upd_hist = HIST_W'($urandom);
      bus.upd_pc   = ($urandom_range(0, 3) == 0) ? bus.req_pc : IDX_W'($urandom_range(0, 7));
      bus.taken    = 1'($urandom_range(0, 1));
      bus.upd_pred = ($urandom_range(0, 3) == 0) ? ~bus.taken : bus.taken;
      if (n == 1000) do_reset();
      tick();
    end
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
